// File: rtl/shared_mem_ctrl.sv
// Main-memory responder for two snooping caches: captures one-cycle requests,
// arbitrates round-robin, serves one fixed-latency access at a time.
`ifndef IOSTATEWIDTH
`define IOSTATEWIDTH 2
`endif
`ifndef IDEL
`define IDEL 2'b00
`endif
`ifndef RD
`define RD 2'b01
`endif
`ifndef WT
`define WT 2'b10
`endif
`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif
`ifndef WORDWIDTH
`define WORDWIDTH 32
`endif

module shared_mem_ctrl #(
    parameter int MEM_AW = 6,
    parameter int RD_LAT = 4,
    parameter int WR_LAT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [`IOSTATEWIDTH-1:0] rwFromC0,
    input  logic [`IOSTATEWIDTH-1:0] rwFromC1,
    input  logic [`ADDRWIDTH-1:0]    addrFromC0,
    input  logic [`ADDRWIDTH-1:0]    addrFromC1,
    input  logic [`WORDWIDTH-1:0]    dataFromC0,
    input  logic [`WORDWIDTH-1:0]    dataFromC1,
    output logic                     readEnToC0,
    output logic                     readEnToC1,
    output logic                     writeDoneToC0,
    output logic                     writeDoneToC1,
    output logic [`WORDWIDTH-1:0]    dataToC0,
    output logic [`WORDWIDTH-1:0]    dataToC1,
    output logic                     protoErr
);

    localparam int CW = 16;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, next_state;

    logic [`IOSTATEWIDTH-1:0] in_rw   [2];
    logic [`ADDRWIDTH-1:0]    in_addr [2];
    logic [`WORDWIDTH-1:0]    in_data [2];
    logic [1:0]               in_req;

    logic [1:0]               pend_valid;
    logic [`IOSTATEWIDTH-1:0] pend_rw   [2];
    logic [`ADDRWIDTH-1:0]    pend_addr [2];
    logic [`WORDWIDTH-1:0]    pend_data [2];

    logic                     cur;
    logic                     rr_ptr;
    logic [CW-1:0]            cnt;
    logic                     grant_valid;
    logic                     grant_port;
    logic                     contended;
    logic                     done;
    logic [MEM_AW-1:0]        cur_idx;

    logic [1:0]               rd_en;
    logic [1:0]               wr_done;
    logic [`WORDWIDTH-1:0]    rd_data [2];
    logic                     proto_err;

    logic [`WORDWIDTH-1:0]    mem [2**MEM_AW];

    assign in_rw[0]   = rwFromC0;
    assign in_rw[1]   = rwFromC1;
    assign in_addr[0] = addrFromC0;
    assign in_addr[1] = addrFromC1;
    assign in_data[0] = dataFromC0;
    assign in_data[1] = dataFromC1;

    // Undefined rw encodings are simply not requests.
    assign in_req[0] = (rwFromC0 == `RD) || (rwFromC0 == `WT);
    assign in_req[1] = (rwFromC1 == `RD) || (rwFromC1 == `WT);

    assign cur_idx = pend_addr[cur][MEM_AW-1:0];

    assign readEnToC0    = rd_en[0];
    assign readEnToC1    = rd_en[1];
    assign writeDoneToC0 = wr_done[0];
    assign writeDoneToC1 = wr_done[1];
    assign dataToC0      = rd_data[0];
    assign dataToC1      = rd_data[1];
    assign protoErr      = proto_err;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        contended   = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (pend_valid != 2'b00) begin
                    grant_valid = 1'b1;
                    contended   = &pend_valid;
                    grant_port  = contended ? rr_ptr : pend_valid[1];
                    next_state  = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A pending slot stays valid through service, so "outstanding" is just pend_valid.
    // The round-robin pointer only moves when both ports were contending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 2'b00;
            rd_en      <= 2'b00;
            wr_done    <= 2'b00;
            proto_err  <= 1'b0;
            cur        <= 1'b0;
            rr_ptr     <= 1'b0;
            cnt        <= '0;
            for (int i = 0; i < 2; i++) begin
                pend_rw[i]   <= `IDEL;
                pend_addr[i] <= '0;
                pend_data[i] <= '0;
                rd_data[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (in_req[i]) begin
                    if (pend_valid[i]) begin
                        proto_err <= 1'b1;
                    end else begin
                        pend_valid[i] <= 1'b1;
                        pend_rw[i]    <= in_rw[i];
                        pend_addr[i]  <= in_addr[i];
                        pend_data[i]  <= in_data[i];
                        rd_en[i]      <= 1'b0;
                        wr_done[i]    <= 1'b0;
                        rd_data[i]    <= '0;
                    end
                end
            end
            if (grant_valid) begin
                cur <= grant_port;
                if (contended) rr_ptr <= ~grant_port;
                cnt <= (pend_rw[grant_port] == `RD) ? CW'(RD_LAT - 1) : CW'(WR_LAT - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (done) begin
                pend_valid[cur] <= 1'b0;
                if (pend_rw[cur] == `RD) begin
                    rd_data[cur] <= mem[cur_idx];
                    rd_en[cur]   <= 1'b1;
                end else begin
                    wr_done[cur] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && done && pend_rw[cur] == `WT) mem[cur_idx] <= pend_data[cur];
    end

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Directed testbench for shared_mem_ctrl: latency, round-robin, hold, protocol error,
// reset abort and address aliasing.
`ifndef IOSTATEWIDTH
`define IOSTATEWIDTH 2
`endif
`ifndef IDEL
`define IDEL 2'b00
`endif
`ifndef RD
`define RD 2'b01
`endif
`ifndef WT
`define WT 2'b10
`endif
`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif
`ifndef WORDWIDTH
`define WORDWIDTH 32
`endif

module tb_shared_mem_ctrl;

    logic                     clk;
    logic                     reset;
    logic [`IOSTATEWIDTH-1:0] rwFromC0, rwFromC1;
    logic [`ADDRWIDTH-1:0]    addrFromC0, addrFromC1;
    logic [`WORDWIDTH-1:0]    dataFromC0, dataFromC1;
    logic                     readEnToC0, readEnToC1;
    logic                     writeDoneToC0, writeDoneToC1;
    logic [`WORDWIDTH-1:0]    dataToC0, dataToC1;
    logic                     protoErr;

    int checks = 0;
    int errors = 0;

    shared_mem_ctrl #(.MEM_AW(6), .RD_LAT(4), .WR_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .rwFromC0(rwFromC0), .rwFromC1(rwFromC1),
        .addrFromC0(addrFromC0), .addrFromC1(addrFromC1),
        .dataFromC0(dataFromC0), .dataFromC1(dataFromC1),
        .readEnToC0(readEnToC0), .readEnToC1(readEnToC1),
        .writeDoneToC0(writeDoneToC0), .writeDoneToC1(writeDoneToC1),
        .dataToC0(dataToC0), .dataToC1(dataToC1),
        .protoErr(protoErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Each tick advances one cycle; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic [`IOSTATEWIDTH-1:0] rw,
                         input logic [`ADDRWIDTH-1:0] a, input logic [`WORDWIDTH-1:0] d);
        if (port == 0) begin
            rwFromC0 = rw; addrFromC0 = a; dataFromC0 = d;
        end else begin
            rwFromC1 = rw; addrFromC1 = a; dataFromC1 = d;
        end
    endtask

    task automatic idle_all();
        rwFromC0 = `IDEL;
        rwFromC1 = `IDEL;
    endtask

    task automatic reset_dut();
        idle_all();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({readEnToC0, readEnToC1, writeDoneToC0, writeDoneToC1, protoErr} !== 5'b0) begin
            $display("[TB] FAIL reset_flags actual=%b expected=00000",
                     {readEnToC0, readEnToC1, writeDoneToC0, writeDoneToC1, protoErr});
            errors++;
        end
        checks++;
        if ((dataToC0 | dataToC1) !== 32'h0) begin
            $display("[TB] FAIL reset_data actual=%h/%h expected=0/0", dataToC0, dataToC1);
            errors++;
        end
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        reset_dut();
        drive(0, `WT, 32'h05, 32'hDEADBEEF);
        tick(); idle_all();
        repeat (4) tick();
        checks++;
        if (writeDoneToC0 !== 1'b0) begin
            $display("[TB] FAIL wr_early actual=%b expected=0", writeDoneToC0); errors++;
        end
        tick();
        checks++;
        if (writeDoneToC0 !== 1'b1) begin
            $display("[TB] FAIL wr_done_c6 actual=%b expected=1", writeDoneToC0); errors++;
        end
        drive(0, `RD, 32'h05, 32'h0);
        tick(); idle_all();
        checks++;
        if (writeDoneToC0 !== 1'b0) begin
            $display("[TB] FAIL wr_done_clear actual=%b expected=0", writeDoneToC0); errors++;
        end
        repeat (4) tick();
        checks++;
        if (readEnToC0 !== 1'b0) begin
            $display("[TB] FAIL rd_early actual=%b expected=0", readEnToC0); errors++;
        end
        tick();
        checks++;
        if (readEnToC0 !== 1'b1 || dataToC0 !== 32'hDEADBEEF) begin
            $display("[TB] FAIL rd_back actual=%b/%h expected=1/deadbeef", readEnToC0, dataToC0);
            errors++;
        end
    endtask

    task automatic test_round_robin();
        reset_dut();
        drive(0, `RD, 32'h01, 32'h0);
        drive(1, `RD, 32'h02, 32'h0);
        tick(); idle_all();
        repeat (4) tick();
        checks++;
        if (readEnToC0 !== 1'b0) begin
            $display("[TB] FAIL rr1_c0_early actual=%b expected=0", readEnToC0); errors++;
        end
        tick();
        checks++;
        if (readEnToC0 !== 1'b1 || readEnToC1 !== 1'b0) begin
            $display("[TB] FAIL rr1_c6 actual=%b%b expected=10", readEnToC0, readEnToC1); errors++;
        end
        repeat (4) tick();
        checks++;
        if (readEnToC1 !== 1'b0) begin
            $display("[TB] FAIL rr1_c1_early actual=%b expected=0", readEnToC1); errors++;
        end
        tick();
        checks++;
        if (readEnToC1 !== 1'b1) begin
            $display("[TB] FAIL rr1_c1_c11 actual=%b expected=1", readEnToC1); errors++;
        end
        // Second contention round: port 1 is now favoured.
        drive(0, `RD, 32'h01, 32'h0);
        drive(1, `RD, 32'h02, 32'h0);
        tick(); idle_all();
        checks++;
        if (readEnToC0 !== 1'b0 || readEnToC1 !== 1'b0) begin
            $display("[TB] FAIL rr2_clear actual=%b%b expected=00", readEnToC0, readEnToC1); errors++;
        end
        repeat (5) tick();
        checks++;
        if (readEnToC1 !== 1'b1 || readEnToC0 !== 1'b0) begin
            $display("[TB] FAIL rr2_c6 actual=%b%b expected=01", readEnToC0, readEnToC1); errors++;
        end
        repeat (4) tick();
        checks++;
        if (readEnToC0 !== 1'b0) begin
            $display("[TB] FAIL rr2_c0_early actual=%b expected=0", readEnToC0); errors++;
        end
        tick();
        checks++;
        if (readEnToC0 !== 1'b1) begin
            $display("[TB] FAIL rr2_c0_c11 actual=%b expected=1", readEnToC0); errors++;
        end
    endtask

    task automatic test_hold();
        int held = 0;
        repeat (20) begin
            tick();
            if (readEnToC0 === 1'b1) held++;
        end
        checks++;
        if (held !== 20) begin
            $display("[TB] FAIL hold_cycles actual=%0d expected=20", held); errors++;
        end
        drive(0, `RD, 32'h03, 32'h0);
        tick(); idle_all();
        checks++;
        if (readEnToC0 !== 1'b0 || protoErr !== 1'b0) begin
            $display("[TB] FAIL hold_fall actual=%b/%b expected=0/0", readEnToC0, protoErr); errors++;
        end
        repeat (5) tick();
        checks++;
        if (readEnToC0 !== 1'b1) begin
            $display("[TB] FAIL hold_next actual=%b expected=1", readEnToC0); errors++;
        end
    endtask

    task automatic test_duplicate();
        int rises = 0;
        logic prev;
        reset_dut();
        drive(0, `RD, 32'h01, 32'h0);
        tick(); idle_all();
        tick();
        checks++;
        if (protoErr !== 1'b0) begin
            $display("[TB] FAIL dup_c2 actual=%b expected=0", protoErr); errors++;
        end
        drive(0, `RD, 32'h01, 32'h0);
        tick(); idle_all();
        checks++;
        if (protoErr !== 1'b1) begin
            $display("[TB] FAIL dup_c3 actual=%b expected=1", protoErr); errors++;
        end
        prev = readEnToC0;
        repeat (20) begin
            tick();
            if (readEnToC0 === 1'b1 && prev !== 1'b1) rises++;
            prev = readEnToC0;
        end
        checks++;
        if (rises !== 1 || protoErr !== 1'b1) begin
            $display("[TB] FAIL dup_once actual=%0d/%b expected=1/1", rises, protoErr); errors++;
        end
    endtask

    task automatic test_reset_midbusy();
        reset_dut();
        drive(1, `WT, 32'h07, 32'h5555);
        tick(); idle_all();
        repeat (5) tick();
        checks++;
        if (writeDoneToC1 !== 1'b1) begin
            $display("[TB] FAIL abort_prewrite actual=%b expected=1", writeDoneToC1); errors++;
        end
        drive(1, `WT, 32'h07, 32'h1234);
        tick(); idle_all();
        tick();
        drive(1, `RD, 32'h07, 32'h0);
        tick(); idle_all();
        checks++;
        if (protoErr !== 1'b1) begin
            $display("[TB] FAIL abort_dup actual=%b expected=1", protoErr); errors++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({readEnToC0, readEnToC1, writeDoneToC0, writeDoneToC1, protoErr} !== 5'b0 ||
            (dataToC0 | dataToC1) !== 32'h0) begin
            $display("[TB] FAIL abort_outputs actual=%b expected=00000",
                     {readEnToC0, readEnToC1, writeDoneToC0, writeDoneToC1, protoErr});
            errors++;
        end
        drive(1, `RD, 32'h07, 32'h0);
        tick(); idle_all();
        repeat (5) tick();
        checks++;
        if (readEnToC1 !== 1'b1 || dataToC1 !== 32'h5555) begin
            $display("[TB] FAIL abort_readback actual=%b/%h expected=1/00005555", readEnToC1, dataToC1);
            errors++;
        end
    endtask

    task automatic test_alias();
        drive(0, `WT, 32'h45, 32'hA);
        tick(); idle_all();
        repeat (5) tick();
        drive(1, `RD, 32'h05, 32'h0);
        tick(); idle_all();
        repeat (5) tick();
        checks++;
        if (readEnToC1 !== 1'b1 || dataToC1 !== 32'hA) begin
            $display("[TB] FAIL alias_read actual=%b/%h expected=1/0000000a", readEnToC1, dataToC1);
            errors++;
        end
        // Encoding 2'b11 must be ignored: the held write-done flag survives.
        drive(0, 2'b11, 32'h05, 32'h0);
        tick(); idle_all();
        repeat (6) tick();
        checks++;
        if (writeDoneToC0 !== 1'b1 || readEnToC0 !== 1'b0 || protoErr !== 1'b0) begin
            $display("[TB] FAIL undef_rw actual=%b%b%b expected=100", writeDoneToC0, readEnToC0, protoErr);
            errors++;
        end
    endtask

    initial begin
        reset = 1'b1;
        rwFromC0 = `IDEL; rwFromC1 = `IDEL;
        addrFromC0 = '0; addrFromC1 = '0;
        dataFromC0 = '0; dataFromC1 = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_hold();
        test_duplicate();
        test_reset_midbusy();
        test_alias();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
